// File: rtl/counter_updown_mod.sv
// Modulo up/down counter with load, wrap/saturate mode, terminal count and cascade carry.
// Optional prescaler (step once per PRE enabled cycles) is compiled in with `CNT_PRESCALE_EN.
module counter_updown_mod #(
  parameter int dw      = 8,
  parameter int MODULUS = 60,
  parameter int RST_VAL = 0,
  parameter int PRE     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          up,
  input  logic          sat,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  output logic [dw-1:0] result,
  output logic          tc,
  output logic          carry
);

  localparam logic [dw-1:0] max_val = dw'(MODULUS - 1);
  localparam logic [dw-1:0] rst_val = dw'(RST_VAL);
  localparam logic [dw-1:0] one_val = dw'(1);

  logic [dw-1:0] result_q, result_d;
  logic          carry_q, carry_d;
  logic          step;

`ifdef CNT_PRESCALE_EN
  localparam int            pw      = (PRE > 2) ? $clog2(PRE) : 1;
  localparam logic [pw-1:0] pre_max = pw'(PRE - 1);
  localparam logic [pw-1:0] pre_one = pw'(1);

  logic [pw-1:0] pre_cnt_q, pre_cnt_d;

  // Load discards any partially elapsed interval; reset does so in the flop below.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    step      = 1'b0;
    if (load) begin
      pre_cnt_d = '0;
    end else if (ena) begin
      if (pre_cnt_q == pre_max) begin
        pre_cnt_d = '0;
        step      = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + pre_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end
`else
  assign step = ena;
`endif

  // Bounds are compared before stepping so the count never overflows dw bits.
  always_comb begin
    result_d = result_q;
    carry_d  = 1'b0;
    if (load) begin
      result_d = (load_val > max_val) ? max_val : load_val;
    end else if (step) begin
      if (up) begin
        if (result_q != max_val) begin
          result_d = result_q + one_val;
        end else if (!sat) begin
          result_d = '0;
          carry_d  = 1'b1;
        end
      end else begin
        if (result_q != '0) begin
          result_d = result_q - one_val;
        end else if (!sat) begin
          result_d = max_val;
          carry_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= rst_val;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign tc     = up ? (result_q == max_val) : (result_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: directed vector table, hand sequences (wrap, cascade,
// back-to-back carry, prescale) and a randomized run against an arithmetic reference model.
module tb_counter_updown_mod;

`ifdef CNT_PRESCALE_EN
  localparam int PRE_DIV = 4;
`else
  localparam int PRE_DIV = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, load, ena, up, sat;
  logic [7:0] load_val;
  logic [7:0] result;
  logic       tc, carry;

  logic       casc_reset, casc_ena;
  logic [7:0] a_result, b_result;
  logic       a_tc, a_carry, b_tc, b_carry;

  logic       m2_reset, m2_ena;
  logic [7:0] m2_result;
  logic       m2_tc, m2_carry;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.dw(8), .MODULUS(60), .RST_VAL(0), .PRE(4)) u_dut (
    .clk(clk), .reset(reset), .ena(ena), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .result(result), .tc(tc), .carry(carry));

  counter_updown_mod #(.dw(8), .MODULUS(60), .RST_VAL(0), .PRE(4)) u_a (
    .clk(clk), .reset(casc_reset), .ena(casc_ena), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(8'd0), .result(a_result), .tc(a_tc), .carry(a_carry));

  counter_updown_mod #(.dw(8), .MODULUS(60), .RST_VAL(0), .PRE(4)) u_b (
    .clk(clk), .reset(casc_reset), .ena(a_carry), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(8'd0), .result(b_result), .tc(b_tc), .carry(b_carry));

  counter_updown_mod #(.dw(8), .MODULUS(2), .RST_VAL(1), .PRE(4)) u_m2 (
    .clk(clk), .reset(m2_reset), .ena(m2_ena), .up(1'b1), .sat(1'b0), .load(1'b0),
    .load_val(8'd0), .result(m2_result), .tc(m2_tc), .carry(m2_carry));

  typedef struct {
    int val;
    int carry;
    int pre;
  } mstate_t;

  typedef struct {
    logic       reset, load, ena, up, sat;
    logic [7:0] load_val;
    logic [7:0] exp_result;
    logic       exp_carry, exp_tc;
  } vec_t;

  vec_t vecs[16];

  // Reference: the counting rules applied to plain integers.
  function automatic mstate_t model_next(mstate_t s, int modulus, int rst_val, bit rst,
                                         bit ld, bit en, bit u, bit sa, int lv);
    mstate_t n;
    bit tk;
    n = s;
    n.carry = 0;
    tk = 1'b0;
    if (rst) begin
      n.val = rst_val;
      n.pre = 0;
    end else if (ld) begin
      n.val = (lv < modulus) ? lv : modulus - 1;
      n.pre = 0;
    end else if (en) begin
      if (PRE_DIV == 1) tk = 1'b1;
      else begin
        tk = (s.pre == PRE_DIV - 1);
        n.pre = tk ? 0 : s.pre + 1;
      end
      if (tk) begin
        if (u) begin
          if (s.val < modulus - 1) n.val = s.val + 1;
          else if (!sa) begin n.val = 0; n.carry = 1; end
        end else begin
          if (s.val > 0) n.val = s.val - 1;
          else if (!sa) begin n.val = modulus - 1; n.carry = 1; end
        end
      end
    end
    return n;
  endfunction

  function automatic int model_tc(mstate_t s, int modulus, bit u);
    return u ? int'(s.val == modulus - 1) : int'(s.val == 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  mstate_t m, ma, mb, mm2;
  bit      bena;
  int      prev_b, prev_ac;

  initial begin
    reset = 1'b1; load = 1'b0; ena = 1'b0; up = 1'b0; sat = 1'b0; load_val = '0;
    casc_reset = 1'b1; casc_ena = 1'b0;
    m2_reset = 1'b1; m2_ena = 1'b0;

    //           rst   ld    ena   up    sat   ld_val  result cy    tc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2,   8'd2,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd1,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd59, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2,   8'd2,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd1,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd0,  1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd0,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd200, 8'd59, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd59, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7,   8'd0,  1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd37,  8'd37, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1};

    repeat (2) tick();
    check("reset_result", result, 0);
    check("reset_carry", carry, 0);
    check("reset_tc_down", tc, 1);
    check("m2_reset_result", m2_result, 1);

    // Directed table; stepping rows are held for a full prescale interval.
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].reset; load = vecs[i].load; ena = vecs[i].ena;
      up = vecs[i].up; sat = vecs[i].sat; load_val = vecs[i].load_val;
      if (vecs[i].ena && !vecs[i].load && !vecs[i].reset) repeat (PRE_DIV - 1) tick();
      tick();
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
      check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
    end

    // tc follows up within the cycle (result is 0 here).
    up = 1'b1; #1; check("tc_comb_up", tc, 0);
    up = 1'b0; #1; check("tc_comb_down", tc, 1);

    // Up wrap over the full range.
    reset = 1'b1; load = 1'b0; ena = 1'b0; up = 1'b1; sat = 1'b0;
    tick();
    reset = 1'b0; ena = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      repeat (PRE_DIV) tick();
      check($sformatf("upwrap%0d_result", k), result, k % 60);
      check($sformatf("upwrap%0d_carry", k), carry, int'(k == 60));
      check($sformatf("upwrap%0d_tc", k), tc, int'((k % 60) == 59));
    end
    ena = 1'b0;
    tick();
    check("upwrap_carry_drop", carry, 0);

`ifdef CNT_PRESCALE_EN
    // Enable gaps pause the prescaler; load restarts its interval.
    reset = 1'b1; tick(); reset = 1'b0;
    ena = 1'b1; repeat (6) tick();
    ena = 1'b0; repeat (3) tick();
    check("pre_gap_mid", result, 1);
    ena = 1'b1; repeat (6) tick();
    check("pre_gap_result", result, 3);
    reset = 1'b1; tick(); reset = 1'b0;
    ena = 1'b1; repeat (2) tick();
    load = 1'b1; load_val = 8'd10; tick(); load = 1'b0;
    repeat (3) tick();
    check("pre_load_hold", result, 10);
    tick();
    check("pre_load_step", result, 11);
    ena = 1'b0;
`endif

    // Cascade: B enabled by A's carry.
    tick();
    casc_reset = 1'b0; casc_ena = 1'b1;
    ma = '{val: 0, carry: 0, pre: 0};
    mb = '{val: 0, carry: 0, pre: 0};
    prev_b = b_result; prev_ac = a_carry;
    for (int c = 0; c < 121; c++) begin
      if (c == 120) casc_ena = 1'b0;
      bena = (ma.carry != 0);
      tick();
      ma = model_next(ma, 60, 0, 1'b0, 1'b0, casc_ena, 1'b1, 1'b0, 0);
      mb = model_next(mb, 60, 0, 1'b0, 1'b0, bena, 1'b1, 1'b0, 0);
      check("casc_a", a_result, ma.val);
      check("casc_a_carry", a_carry, ma.carry);
      check("casc_b", b_result, mb.val);
      if (b_result != prev_b) check("casc_b_after_wrap", prev_ac, 1);
      prev_b = b_result; prev_ac = a_carry;
    end
    check("casc_final_a", a_result, (120 / PRE_DIV) % 60);
    check("casc_final_b", b_result, ((120 / PRE_DIV) / 60) / PRE_DIV);

    // MODULUS = 2: consecutive wraps give back-to-back carries.
    m2_reset = 1'b0; m2_ena = 1'b1;
    mm2 = '{val: 1, carry: 0, pre: 0};
    for (int c = 0; c < 6 * PRE_DIV; c++) begin
      tick();
      mm2 = model_next(mm2, 2, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      check("m2_result", m2_result, mm2.val);
      check("m2_carry", m2_carry, mm2.carry);
      check("m2_tc", m2_tc, model_tc(mm2, 2, 1'b1));
    end
    m2_ena = 1'b0;

    // Randomized run against the reference model.
    reset = 1'b1; load = 1'b0; ena = 1'b0;
    tick();
    m = '{val: 0, carry: 0, pre: 0};
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 9) == 0);
      ena = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1);
      sat = ($urandom_range(0, 3) == 0);
      load_val = 8'($urandom_range(0, 255));
      tick();
      m = model_next(m, 60, 0, reset, load, ena, up, sat, int'(load_val));
      check("rand_result", result, m.val);
      check("rand_carry", carry, m.carry);
      check("rand_tc", tc, model_tc(m, 60, up));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
